// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared encodings, widths and defaults for frame_validator
//
// Purpose: FSM state encoding, frame field widths, error-bit positions,
// default expected section values and the captured-frame record type.
package frame_pkg;

  localparam int PREAMBLE_W = 32;
  localparam int TYPE_W     = 16;
  localparam int CONST_W    = 32;
  localparam int ID_W       = 32;
  localparam int TEMP_W     = 16;
  localparam int STATE_W    = 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CHECK      = 3'd1;
  localparam logic [2:0] ST_COMMIT     = 3'd2;
  localparam logic [2:0] ST_REJECT     = 3'd3;
  localparam logic [2:0] ST_WAIT_CLEAR = 3'd4;

  // Positions inside last_error = {preamble_bad, type_mismatch, constant_bad}
  localparam int ERR_PREAMBLE = 2;
  localparam int ERR_TYPE     = 1;
  localparam int ERR_CONSTANT = 0;

  localparam logic [PREAMBLE_W-1:0] DEF_EXP_PREAMBLE = 32'hAAAA_AAAA;
  localparam logic [CONST_W-1:0]    DEF_EXP_CONSTANT = 32'h0000_0000;

  typedef struct packed {
    logic [PREAMBLE_W-1:0] preamble;
    logic [TYPE_W-1:0]     type_1;
    logic [TYPE_W-1:0]     type_2;
    logic [CONST_W-1:0]    constant;
    logic [ID_W-1:0]       thermostat_id;
    logic [TEMP_W-1:0]     room_temp;
    logic [TEMP_W-1:0]     set_temp;
    logic [STATE_W-1:0]    state;
  } frame_t;

endpackage

// File: rtl/sat_counter8.sv
// rtl/sat_counter8.sv - 8-bit event counter that sticks at 255
//
// Ports: clock, reset_n (sync, active-low), enable (count one event),
//        count (current value, never wraps).
module sat_counter8 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic [7:0] count
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/frame_validator.sv
// rtl/frame_validator.sv - checks decoded thermostat frames and holds the last good one
//
// Inputs : clock, reset_n (sync, active-low), full (frame-complete level),
//          preamble, type_1, type_2, constant, thermostat_id, room_temp,
//          set_temp, state (decoded frame fields).
// Outputs: held_id, held_room_temp, held_set_temp, held_state (last good frame),
//          data_valid (held data fresh), new_frame (commit pulse),
//          good_count, bad_count (saturating), last_error (last reject reason).
module frame_validator
  import frame_pkg::*;
#(
  parameter logic [31:0] EXP_PREAMBLE   = DEF_EXP_PREAMBLE,
  parameter logic [31:0] EXP_CONSTANT   = DEF_EXP_CONSTANT,
  parameter int          TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        full,
  input  logic [31:0] preamble,
  input  logic [15:0] type_1,
  input  logic [15:0] type_2,
  input  logic [31:0] constant,
  input  logic [31:0] thermostat_id,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  output logic [31:0] held_id,
  output logic [15:0] held_room_temp,
  output logic [15:0] held_set_temp,
  output logic [7:0]  held_state,
  output logic        data_valid,
  output logic        new_frame,
  output logic [7:0]  good_count,
  output logic [7:0]  bad_count,
  output logic [2:0]  last_error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    fsm_q, fsm_d;
  logic          full_q;
  logic          rise;
  frame_t        shadow;
  logic [2:0]    err_c, err_q;
  logic [TW-1:0] tmo_cnt;
  logic          capture, check_en, commit_en, reject_en;

  assign rise = full & ~full_q;

  // Error bits come from the shadow copy so late input changes cannot leak in.
  always_comb begin
    err_c               = 3'b000;
    err_c[ERR_PREAMBLE] = (shadow.preamble != EXP_PREAMBLE);
    err_c[ERR_TYPE]     = (shadow.type_1 != shadow.type_2);
    err_c[ERR_CONSTANT] = (shadow.constant != EXP_CONSTANT);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) fsm_q <= ST_IDLE;
    else          fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:       if (rise) fsm_d = ST_CHECK;
      ST_CHECK: begin
        // full dropping here means the decoder restarted: drop the frame silently
        if (!full)               fsm_d = ST_IDLE;
        else if (err_c == 3'b0)  fsm_d = ST_COMMIT;
        else                     fsm_d = ST_REJECT;
      end
      ST_COMMIT,
      ST_REJECT:     fsm_d = ST_WAIT_CLEAR;
      ST_WAIT_CLEAR: if (!full) fsm_d = ST_IDLE;
      default:       fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture   = (fsm_q == ST_IDLE) && rise;
    check_en  = (fsm_q == ST_CHECK);
    commit_en = (fsm_q == ST_COMMIT);
    reject_en = (fsm_q == ST_REJECT);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      full_q         <= 1'b0;
      shadow         <= '0;
      err_q          <= 3'b000;
      held_id        <= '0;
      held_room_temp <= '0;
      held_set_temp  <= '0;
      held_state     <= '0;
      new_frame      <= 1'b0;
      last_error     <= 3'b000;
      data_valid     <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      full_q    <= full;
      new_frame <= commit_en;
      if (capture) begin
        shadow <= '{preamble, type_1, type_2, constant,
                    thermostat_id, room_temp, set_temp, state};
      end
      if (check_en) err_q <= err_c;
      if (commit_en) begin
        held_id        <= shadow.thermostat_id;
        held_room_temp <= shadow.room_temp;
        held_set_temp  <= shadow.set_temp;
        held_state     <= shadow.state;
      end
      if (reject_en) last_error <= err_q;
      // A commit on the terminal cycle restarts the window instead of expiring it.
      if (commit_en) begin
        data_valid <= 1'b1;
        tmo_cnt    <= '0;
      end else if (data_valid) begin
        if (tmo_cnt == TMO_LAST) begin
          data_valid <= 1'b0;
          tmo_cnt    <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

  sat_counter8 u_good_count (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (commit_en),
    .count   (good_count)
  );

  sat_counter8 u_bad_count (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (reject_en),
    .count   (bad_count)
  );

endmodule

// File: tb/tb_frame_validator.sv
// tb/tb_frame_validator.sv - randomized self-checking bench for frame_validator
module tb_frame_validator;

  localparam int TMO = 16;

  typedef struct {
    logic [31:0] pre;
    logic [15:0] t1;
    logic [15:0] t2;
    logic [31:0] cst;
    logic [31:0] id;
    logic [15:0] room;
    logic [15:0] set;
    logic [7:0]  st;
  } tb_frame_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        full;
  logic [31:0] preamble, constant, thermostat_id;
  logic [15:0] type_1, type_2, room_temp, set_temp;
  logic [7:0]  state;
  logic [31:0] held_id;
  logic [15:0] held_room_temp, held_set_temp;
  logic [7:0]  held_state, good_count, bad_count;
  logic        data_valid, new_frame;
  logic [2:0]  last_error;

  frame_validator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .full(full),
    .preamble(preamble), .type_1(type_1), .type_2(type_2), .constant(constant),
    .thermostat_id(thermostat_id), .room_temp(room_temp), .set_temp(set_temp),
    .state(state), .held_id(held_id), .held_room_temp(held_room_temp),
    .held_set_temp(held_set_temp), .held_state(held_state),
    .data_valid(data_valid), .new_frame(new_frame), .good_count(good_count),
    .bad_count(bad_count), .last_error(last_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the outputs should be, from the frame rules alone.
  tb_frame_t   m_held;
  int          m_good, m_bad;
  logic [2:0]  m_err;
  bit          m_armed;
  int          m_commit_edge;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_valid();
    return m_armed && ((cyc - m_commit_edge) < TMO);
  endfunction

  function automatic bit is_good(input tb_frame_t f);
    return (f.pre == 32'hAAAA_AAAA) && (f.t1 == f.t2) && (f.cst == 32'h0);
  endfunction

  function automatic logic [2:0] err_of(input tb_frame_t f);
    return {f.pre != 32'hAAAA_AAAA, f.t1 != f.t2, f.cst != 32'h0};
  endfunction

  task automatic model_reset();
    m_held = '{default: '0};
    m_good = 0; m_bad = 0; m_err = 3'b000;
    m_armed = 1'b0; m_commit_edge = 0;
  endtask

  function automatic tb_frame_t rand_frame(input bit want_good);
    tb_frame_t  f;
    logic [2:0] e;
    f.pre  = 32'hAAAA_AAAA;
    f.t1   = 16'($urandom);
    f.t2   = f.t1;
    f.cst  = 32'h0;
    f.id   = $urandom;
    f.room = 16'($urandom);
    f.set  = 16'($urandom);
    f.st   = 8'($urandom);
    if (!want_good) begin
      e = 3'($urandom_range(1, 7));
      if (e[2]) f.pre = f.pre ^ (32'd1 << $urandom_range(0, 31));
      if (e[1]) f.t2  = f.t2 ^ (16'd1 << $urandom_range(0, 15));
      if (e[0]) f.cst = 32'd1 << $urandom_range(0, 31);
    end
    return f;
  endfunction

  task automatic drive(input tb_frame_t f);
    preamble = f.pre; type_1 = f.t1; type_2 = f.t2; constant = f.cst;
    thermostat_id = f.id; room_temp = f.room; set_temp = f.set; state = f.st;
  endtask

  task automatic check_all(input string tag, input bit exp_nf);
    check({tag, ".held_id"},    held_id, m_held.id);
    check({tag, ".held_room"},  32'(held_room_temp), 32'(m_held.room));
    check({tag, ".held_set"},   32'(held_set_temp), 32'(m_held.set));
    check({tag, ".held_state"}, 32'(held_state), 32'(m_held.st));
    check({tag, ".good_count"}, 32'(good_count), 32'(m_good));
    check({tag, ".bad_count"},  32'(bad_count), 32'(m_bad));
    check({tag, ".last_error"}, 32'(last_error), 32'(m_err));
    check({tag, ".data_valid"}, 32'(data_valid), 32'(exp_valid()));
    check({tag, ".new_frame"},  32'(new_frame), 32'(exp_nf));
  endtask

  // One cycle of idle observation: freshness and absence of a commit pulse.
  task automatic step(input string tag);
    @(negedge clock);
    check({tag, ".data_valid"}, 32'(data_valid), 32'(exp_valid()));
    check({tag, ".new_frame"},  32'(new_frame), 32'd0);
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) step(tag);
  endtask

  // Entered at a negedge with full low and the FSM idle; the rise lands at the next edge k.
  task automatic send_frame(input string tag, input tb_frame_t f, input int hold, input bit abort);
    int k;
    drive(f);
    full = 1'b1;
    @(negedge clock);
    k = cyc;
    drive(rand_frame($urandom_range(0, 1) == 1));
    if (abort) full = 1'b0;
    step({tag, ".k1"});
    if (abort) return;
    @(negedge clock);
    if (is_good(f)) begin
      m_held = f;
      if (m_good < 255) m_good++;
      m_armed = 1'b1;
      m_commit_edge = k + 2;
    end else begin
      m_err = err_of(f);
      if (m_bad < 255) m_bad++;
    end
    check_all({tag, ".k2"}, is_good(f));
    idle({tag, ".hold"}, hold);
    full = 1'b0;
    idle({tag, ".clr"}, 2);
  endtask

  tb_frame_t f;
  int        c;

  initial begin
    reset_n = 1'b0;
    full    = 1'b0;
    f = '{default: '0};
    drive(f);
    model_reset();
    repeat (3) @(negedge clock);
    check_all("reset", 1'b0);
    reset_n = 1'b1;
    @(negedge clock);

    f = rand_frame(1'b1); f.t1 = 16'h1234; f.t2 = 16'h1234; f.room = 16'h00D2;
    send_frame("good_d2", f, 3, 1'b0);
    check("good_d2.room", 32'(held_room_temp), 32'h00D2);

    model_reset();
    reset_n = 1'b0; @(negedge clock); reset_n = 1'b1; @(negedge clock);
    f = rand_frame(1'b1); f.pre = 32'hAAAA_AAAB;
    send_frame("bad_pre", f, 1, 1'b0);
    check("bad_pre.err", 32'(last_error), 32'b100);
    check("bad_pre.valid", 32'(data_valid), 32'd0);
    f = rand_frame(1'b1); f.room = 16'h00C8;
    send_frame("good_c8", f, 1, 1'b0);
    check("good_c8.room", 32'(held_room_temp), 32'h00C8);
    check("good_c8.err", 32'(last_error), 32'b100);

    f = rand_frame(1'b1); f.t1 = 16'h1234; f.t2 = 16'h1235; f.cst = 32'h1;
    send_frame("type_cst", f, 2, 1'b0);
    check("type_cst.err", 32'(last_error), 32'b011);

    f = rand_frame(1'b1);
    send_frame("hold50", f, 50, 1'b0);
    f = rand_frame(1'b1);
    send_frame("rearm", f, 1, 1'b0);

    idle("timeout", TMO + 4);
    check("timeout.valid", 32'(data_valid), 32'd0);

    f = rand_frame(1'b1);
    send_frame("tmo_a", f, 1, 1'b0);
    c = m_commit_edge;
    while (cyc < c + TMO - 3) step("tmo_gap");
    f = rand_frame(1'b1);
    send_frame("tmo_b", f, 1, 1'b0);
    check("coincide.edge", 32'(m_commit_edge), 32'(c + TMO));

    for (int i = 0; i < 150; i++) begin
      f = rand_frame($urandom_range(0, 1) == 1);
      send_frame("rand", f, $urandom_range(1, 4), $urandom_range(0, 9) == 0);
      idle("rand_gap", $urandom_range(0, 20));
    end

    for (int i = 0; i < 300; i++) begin
      f = rand_frame(1'b0);
      send_frame("bad300", f, 1, 1'b0);
    end
    check("bad300.count", 32'(bad_count), 32'd255);

    f = rand_frame(1'b1);
    drive(f);
    full = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    full    = 1'b0;
    @(negedge clock);
    model_reset();
    check_all("rst_check", 1'b0);
    reset_n = 1'b1;
    idle("post_rst", 6);
    check("post_rst.good", 32'(good_count), 32'd0);
    check("post_rst.held", held_id, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
